m_dbus_arbiter: RTL and testbench

//  Single-owner arbiter and sequencer for the shared data bus (dbus). Two requesters share it:
//  the LSU (loads/stores from execute, already translated by the MMU) and the MMU page-table

---
 rtl/m_dbus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_m_dbus_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/m_dbus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : m_dbus_arbiter
// Description : Single-owner dbus arbiter between the LSU and the MMU page-table
//               walker, with LSU flush draining and a per-transaction watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module m_dbus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TMO_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_ld_req,
    input  logic                  lsu_st_req,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_byte_en,
    input  logic                  lsu_flush,
    input  logic                  ptw_req,
    input  logic [ADDR_W-1:0]     ptw_addr,
    input  logic [DATA_W-1:0]     dbus_rdata,
    input  logic                  dbus_ack,
    output logic [ADDR_W-1:0]     dbus_addr,
    output logic [DATA_W-1:0]     dbus_wdata,
    output logic [DATA_W/8-1:0]   dbus_byte_en,
    output logic                  dbus_ld_req,
    output logic                  dbus_st_req,
    output logic                  lsu_ack,
    output logic                  lsu_err,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  ptw_ack,
    output logic                  ptw_err,
    output logic [DATA_W-1:0]     ptw_rdata,
    output logic                  arb_busy
);

    localparam int              c_be_w    = DATA_W / 8;
    localparam logic [TMO_W-1:0] c_tmo_max = '1;
    localparam logic [TMO_W-1:0] c_tmo_one = TMO_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LSU   = 2'd1,
        S_PTW   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic                  w_tmo;
    logic                  w_grant_lsu;
    logic                  w_grant_ptw;
    logic                  w_clr_req;

    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [c_be_w-1:0]     r_byte_en;
    logic                  r_ld_req;
    logic                  r_st_req;

    assign w_tmo = (r_tmo_cnt == c_tmo_max);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and grant decode; an ack always beats a coincident timeout
    always_comb begin
        w_state_nxt = r_state;
        w_grant_lsu = 1'b0;
        w_grant_ptw = 1'b0;
        w_clr_req   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ptw_req) begin
                    w_grant_ptw = 1'b1;
                    w_state_nxt = S_PTW;
                end else if ((lsu_ld_req || lsu_st_req) && !lsu_flush) begin
                    w_grant_lsu = 1'b1;
                    w_state_nxt = S_LSU;
                end
            end
            S_LSU: begin
                if (dbus_ack || w_tmo) begin
                    w_clr_req   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (lsu_flush) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_PTW, S_DRAIN: begin
                if (dbus_ack || w_tmo) begin
                    w_clr_req   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_grant_lsu || w_grant_ptw) begin
            r_tmo_cnt <= '0;
        end else if (r_state != S_IDLE) begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
        end
    end

    // Bus request registers, held stable for the whole transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_byte_en <= '0;
            r_ld_req  <= 1'b0;
            r_st_req  <= 1'b0;
        end else if (w_grant_ptw) begin
            r_addr    <= ptw_addr;
            r_wdata   <= '0;
            r_byte_en <= '1;
            r_ld_req  <= 1'b1;
            r_st_req  <= 1'b0;
        end else if (w_grant_lsu) begin
            r_addr    <= lsu_addr;
            r_wdata   <= lsu_wdata;
            r_byte_en <= lsu_byte_en;
            r_ld_req  <= lsu_ld_req;
            r_st_req  <= lsu_st_req;
        end else if (w_clr_req) begin
            r_ld_req  <= 1'b0;
            r_st_req  <= 1'b0;
        end
    end

    assign dbus_addr    = r_addr;
    assign dbus_wdata   = r_wdata;
    assign dbus_byte_en = r_byte_en;
    assign dbus_ld_req  = r_ld_req;
    assign dbus_st_req  = r_st_req;

    // A flush in the completion/timeout cycle means nobody is waiting for the result
    assign lsu_ack   = dbus_ack && (r_state == S_LSU) && !lsu_flush;
    assign lsu_err   = w_tmo && !dbus_ack && (r_state == S_LSU) && !lsu_flush;
    assign ptw_ack   = dbus_ack && (r_state == S_PTW);
    assign ptw_err   = w_tmo && !dbus_ack && (r_state == S_PTW);
    assign lsu_rdata = dbus_rdata;
    assign ptw_rdata = dbus_rdata;
    assign arb_busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_m_dbus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_m_dbus_arbiter
// Description : Directed self-checking bench for m_dbus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_dbus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_ld_req, lsu_st_req, lsu_flush, ptw_req, dbus_ack;
    logic [31:0] lsu_addr, lsu_wdata, ptw_addr, dbus_rdata;
    logic [3:0]  lsu_byte_en;
    logic [31:0] dbus_addr, dbus_wdata, lsu_rdata, ptw_rdata;
    logic [3:0]  dbus_byte_en;
    logic        dbus_ld_req, dbus_st_req, lsu_ack, lsu_err, ptw_ack, ptw_err, arb_busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_cyc;

    m_dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .TMO_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .lsu_ld_req(lsu_ld_req), .lsu_st_req(lsu_st_req), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_byte_en(lsu_byte_en), .lsu_flush(lsu_flush),
        .ptw_req(ptw_req), .ptw_addr(ptw_addr),
        .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_byte_en(dbus_byte_en),
        .dbus_ld_req(dbus_ld_req), .dbus_st_req(dbus_st_req),
        .lsu_ack(lsu_ack), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
        .ptw_ack(ptw_ack), .ptw_err(ptw_err), .ptw_rdata(ptw_rdata),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1;
        lsu_ld_req = 0; lsu_st_req = 0; lsu_flush = 0; ptw_req = 0; dbus_ack = 0;
        lsu_addr = '0; lsu_wdata = '0; lsu_byte_en = '0; ptw_addr = '0; dbus_rdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ld",   dbus_ld_req, 0);
        check_eq("rst_st",   dbus_st_req, 0);
        check_eq("rst_addr", dbus_addr,   0);
        check_eq("rst_busy", arb_busy,    0);
        rst = 1'b0;
        @(negedge clk);

        // 1: LSU load, ack 3 cycles after the request appears
        lsu_ld_req = 1; lsu_addr = 32'h8000_0010; lsu_byte_en = 4'hF;
        @(negedge clk);
        check_eq("t1_ld",   dbus_ld_req, 1);
        check_eq("t1_addr", dbus_addr,   32'h8000_0010);
        check_eq("t1_busy", arb_busy,    1);
        repeat (3) @(negedge clk);
        check_eq("t1_ld_held", dbus_ld_req, 1);
        check_eq("t1_noack",   lsu_ack,     0);
        dbus_ack = 1; dbus_rdata = 32'hDEAD_BEEF;
        #1;
        check_eq("t1_ack",   lsu_ack,   1);
        check_eq("t1_rdata", lsu_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        dbus_ack = 0; lsu_ld_req = 0;
        check_eq("t1_ld_clr",   dbus_ld_req, 0);
        check_eq("t1_ack_clr",  lsu_ack,     0);
        check_eq("t1_busy_clr", arb_busy,    0);

        // 2: simultaneous PTW and LSU store; PTW wins
        ptw_req = 1; ptw_addr = 32'h0000_4000;
        lsu_st_req = 1; lsu_addr = 32'h9000_0000; lsu_wdata = 32'h1234_5678; lsu_byte_en = 4'h3;
        @(negedge clk);
        check_eq("t2_ptw_ld",  dbus_ld_req,  1);
        check_eq("t2_ptw_st",  dbus_st_req,  0);
        check_eq("t2_ptw_be",  dbus_byte_en, 4'hF);
        check_eq("t2_ptw_adr", dbus_addr,    32'h0000_4000);
        check_eq("t2_ptw_wd",  dbus_wdata,   0);
        dbus_ack = 1; dbus_rdata = 32'hCAFE_0001;
        #1;
        check_eq("t2_ptw_ack", ptw_ack,   1);
        check_eq("t2_ptw_rd",  ptw_rdata, 32'hCAFE_0001);
        check_eq("t2_no_lack", lsu_ack,   0);
        @(negedge clk);
        dbus_ack = 0; ptw_req = 0;
        check_eq("t2_turn_ld", dbus_ld_req, 0);
        check_eq("t2_turn_st", dbus_st_req, 0);
        @(negedge clk);
        check_eq("t2_st",   dbus_st_req,  1);
        check_eq("t2_ld",   dbus_ld_req,  0);
        check_eq("t2_addr", dbus_addr,    32'h9000_0000);
        check_eq("t2_wd",   dbus_wdata,   32'h1234_5678);
        check_eq("t2_be",   dbus_byte_en, 4'h3);
        repeat (2) @(negedge clk);
        check_eq("t2_wd_hold", dbus_wdata,   32'h1234_5678);
        check_eq("t2_be_hold", dbus_byte_en, 4'h3);
        dbus_ack = 1;
        #1;
        check_eq("t2_st_ack", lsu_ack, 1);
        @(negedge clk);
        dbus_ack = 0; lsu_st_req = 0;
        check_eq("t2_st_clr", dbus_st_req, 0);

        // 3: flush while load in flight -> DRAIN, ack 4 cycles later suppressed
        lsu_ld_req = 1; lsu_addr = 32'h8000_0020; lsu_byte_en = 4'hF;
        @(negedge clk);
        check_eq("t3_ld", dbus_ld_req, 1);
        lsu_flush = 1;
        @(negedge clk);
        lsu_flush = 0; lsu_ld_req = 0;
        check_eq("t3_drain_ld",   dbus_ld_req, 1);
        check_eq("t3_drain_busy", arb_busy,    1);
        repeat (3) @(negedge clk);
        check_eq("t3_ld_held", dbus_ld_req, 1);
        dbus_ack = 1; dbus_rdata = 32'h5555_AAAA;
        #1;
        check_eq("t3_no_ack", lsu_ack, 0);
        @(negedge clk);
        dbus_ack = 0;
        check_eq("t3_busy_clr", arb_busy,    0);
        check_eq("t3_ld_clr",   dbus_ld_req, 0);

        // 4: flush in IDLE blocks the grant
        lsu_ld_req = 1; lsu_flush = 1; lsu_addr = 32'h8000_0040;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t4_no_grant", dbus_ld_req, 0);
            check_eq("t4_idle",     arb_busy,    0);
        end
        lsu_ld_req = 0; lsu_flush = 0;
        @(negedge clk);

        // 5: PTW never acked -> ptw_err 255 cycles after the grant edge
        ptw_req = 1; ptw_addr = 32'h0000_8000;
        @(posedge clk);
        n_cyc = 0;
        while (n_cyc < 300) begin
            @(posedge clk);
            n_cyc++;
            @(negedge clk);
            if (ptw_err) break;
        end
        check_eq("t5_err_cycle", n_cyc,   255);
        check_eq("t5_err",       ptw_err, 1);
        check_eq("t5_no_ack",    ptw_ack, 0);
        ptw_req = 0;
        @(negedge clk);
        check_eq("t5_ld_clr",   dbus_ld_req, 0);
        check_eq("t5_busy_clr", arb_busy,    0);
        check_eq("t5_err_clr",  ptw_err,     0);
        lsu_ld_req = 1; lsu_addr = 32'h8000_0030;
        @(negedge clk);
        check_eq("t5_lsu_ld",   dbus_ld_req, 1);
        check_eq("t5_lsu_addr", dbus_addr,   32'h8000_0030);
        dbus_ack = 1; dbus_rdata = 32'h0BAD_F00D;
        #1;
        check_eq("t5_lsu_ack", lsu_ack, 1);
        @(negedge clk);
        dbus_ack = 0; lsu_ld_req = 0;

        // 6: async reset during a store
        lsu_st_req = 1; lsu_addr = 32'h9000_0100; lsu_wdata = 32'hA5A5_A5A5; lsu_byte_en = 4'hC;
        @(negedge clk);
        check_eq("t6_st", dbus_st_req, 1);
        #2;
        rst = 1;
        lsu_st_req = 0;
        #1;
        check_eq("t6_rst_st",   dbus_st_req,  0);
        check_eq("t6_rst_addr", dbus_addr,    0);
        check_eq("t6_rst_wd",   dbus_wdata,   0);
        check_eq("t6_rst_be",   dbus_byte_en, 0);
        check_eq("t6_rst_busy", arb_busy,     0);
        dbus_ack = 1;
        #1;
        check_eq("t6_rst_noack", lsu_ack, 0);
        @(negedge clk);
        rst = 0; dbus_ack = 0;
        @(negedge clk);
        check_eq("t6_post_busy", arb_busy,    0);
        check_eq("t6_post_st",   dbus_st_req, 0);
        check_eq("t6_post_ack",  lsu_ack,     0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
